// File: rtl/iob_native_rr_arbiter_pkg.sv
// Shared definitions for the IOb-native round-robin arbiter: FSM encoding and
// the IOb read predicate (a transfer with no write strobes is a read).
`ifndef IOB_IS_READ
`define IOB_IS_READ(wstrb) (~|(wstrb))
`endif

package iob_native_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    WAIT_RSP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/iob_reg_cke.sv
// Async-reset register with clock enable; holds its value while cke_i is low.
module iob_reg_cke #(
  parameter int         W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         arst_i,
  input  logic         cke_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      q_o <= RST_VAL;
    end else if (cke_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/iob_rr_priority_enc.sv
// Combinational round-robin selector: returns the first set request at or
// after prio_i, searching upward and wrapping modulo N.
module iob_rr_priority_enc #(
  parameter int N     = 2,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [SEL_W-1:0] prio_i,
  output logic [SEL_W-1:0] idx_o,
  output logic             any_o
);

  logic [SEL_W-1:0] cand [N];
  logic [N-1:0]     hit;

  // cand[gi] is the master index gi positions after the pointer
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      logic [SEL_W:0] sum;
      assign sum      = {1'b0, prio_i} + (SEL_W+1)'(gi);
      assign cand[gi] = (sum >= (SEL_W+1)'(N)) ? SEL_W'(sum - (SEL_W+1)'(N)) : SEL_W'(sum);
      assign hit[gi]  = req_i[cand[gi]];
    end
  endgenerate

  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hit[i]) begin
        idx_o = cand[i];
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/iob_native_rr_arbiter.sv
// Round-robin arbiter sharing one IOb-native slave between N masters, with a
// single outstanding read whose response is routed back to its issuer.
module iob_native_rr_arbiter
  import iob_native_rr_arbiter_pkg::*;
#(
  parameter int  N_MASTERS = 2,
  parameter int  ADDR_W    = 16,
  parameter int  DATA_W    = 32,
  localparam int SEL_W     = $clog2(N_MASTERS),
  localparam int STRB_W    = DATA_W / 8
) (
  input  logic                          clk_i,
  input  logic                          cke_i,
  input  logic                          arst_i,
  input  logic [N_MASTERS-1:0]          m_avalid_i,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr_i,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata_i,
  input  logic [N_MASTERS*STRB_W-1:0]   m_wstrb_i,
  output logic [N_MASTERS-1:0]          m_ready_o,
  output logic [N_MASTERS-1:0]          m_rvalid_o,
  output logic [DATA_W-1:0]             m_rdata_o,
  output logic                          s_avalid_o,
  output logic [ADDR_W-1:0]             s_addr_o,
  output logic [DATA_W-1:0]             s_wdata_o,
  output logic [STRB_W-1:0]             s_wstrb_o,
  input  logic                          s_ready_i,
  input  logic                          s_rvalid_i,
  input  logic [DATA_W-1:0]             s_rdata_i,
  output logic [SEL_W-1:0]              owner_o,
  output logic                          busy_o
);

  logic [1:0]       state_q;
  arb_state_t       state_reg, state_next;
  logic [SEL_W-1:0] owner_reg, owner_next;
  logic [SEL_W-1:0] prio_reg, prio_next;
  logic [SEL_W-1:0] owner_inc;
  logic [SEL_W-1:0] sel_idx;
  logic             sel_any;

  logic [ADDR_W-1:0] m_addr_arr  [N_MASTERS];
  logic [DATA_W-1:0] m_wdata_arr [N_MASTERS];
  logic [STRB_W-1:0] m_wstrb_arr [N_MASTERS];

  genvar gi;
  generate
    for (gi = 0; gi < N_MASTERS; gi++) begin : g_unpack
      assign m_addr_arr[gi]  = m_addr_i[gi*ADDR_W +: ADDR_W];
      assign m_wdata_arr[gi] = m_wdata_i[gi*DATA_W +: DATA_W];
      assign m_wstrb_arr[gi] = m_wstrb_i[gi*STRB_W +: STRB_W];
    end
  endgenerate

  iob_rr_priority_enc #(
    .N     (N_MASTERS),
    .SEL_W (SEL_W)
  ) u_prio_enc (
    .req_i  (m_avalid_i),
    .prio_i (prio_reg),
    .idx_o  (sel_idx),
    .any_o  (sel_any)
  );

  iob_reg_cke #(.W(2), .RST_VAL(IDLE)) u_state_reg (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .cke_i  (cke_i),
    .d_i    (state_next),
    .q_o    (state_q)
  );

  iob_reg_cke #(.W(SEL_W), .RST_VAL('0)) u_owner_reg (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .cke_i  (cke_i),
    .d_i    (owner_next),
    .q_o    (owner_reg)
  );

  iob_reg_cke #(.W(SEL_W), .RST_VAL('0)) u_prio_reg (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .cke_i  (cke_i),
    .d_i    (prio_next),
    .q_o    (prio_reg)
  );

  assign state_reg = arb_state_t'(state_q);
  assign owner_inc = (owner_reg == SEL_W'(N_MASTERS - 1)) ? '0 : owner_reg + 1'b1;

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    prio_next  = prio_reg;
    m_ready_o  = '0;
    m_rvalid_o = '0;
    s_avalid_o = 1'b0;
    s_addr_o   = '0;
    s_wdata_o  = '0;
    s_wstrb_o  = '0;

    case (state_reg)
      IDLE: begin
        if (sel_any) begin
          owner_next = sel_idx;
          state_next = GRANT;
        end
      end

      GRANT: begin
        s_avalid_o           = m_avalid_i[owner_reg];
        s_addr_o             = m_addr_arr[owner_reg];
        s_wdata_o            = m_wdata_arr[owner_reg];
        s_wstrb_o            = m_wstrb_arr[owner_reg];
        m_ready_o[owner_reg] = s_ready_i;
        // An owner that withdraws its request loses the grant without
        // advancing the pointer, so it is not penalised in the rotation.
        if (!m_avalid_i[owner_reg]) begin
          state_next = IDLE;
        end else if (s_ready_i) begin
          if (`IOB_IS_READ(m_wstrb_arr[owner_reg])) begin
            state_next = WAIT_RSP;
          end else begin
            state_next = IDLE;
            prio_next  = owner_inc;
          end
        end
      end

      WAIT_RSP: begin
        if (s_rvalid_i) begin
          m_rvalid_o[owner_reg] = 1'b1;
          state_next            = IDLE;
          prio_next             = owner_inc;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign m_rdata_o = s_rdata_i;
  assign owner_o   = owner_reg;
  assign busy_o    = (state_reg != IDLE);

endmodule

// File: tb/tb_iob_native_rr_arbiter.sv
// Directed, table-driven bench for iob_native_rr_arbiter with two masters.
module tb_iob_native_rr_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic            clk = 1'b0;
  logic            cke;
  logic            arst;
  logic [1:0]      m_avalid;
  logic [2*AW-1:0] m_addr;
  logic [2*DW-1:0] m_wdata;
  logic [2*SW-1:0] m_wstrb;
  logic [1:0]      m_ready;
  logic [1:0]      m_rvalid;
  logic [DW-1:0]   m_rdata;
  logic            s_avalid;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [SW-1:0]   s_wstrb;
  logic            s_ready;
  logic            s_rvalid;
  logic [DW-1:0]   s_rdata;
  logic            owner;
  logic            busy;

  always #5 clk = ~clk;

  iob_native_rr_arbiter #(
    .N_MASTERS (2),
    .ADDR_W    (AW),
    .DATA_W    (DW)
  ) dut (
    .clk_i      (clk),
    .cke_i      (cke),
    .arst_i     (arst),
    .m_avalid_i (m_avalid),
    .m_addr_i   (m_addr),
    .m_wdata_i  (m_wdata),
    .m_wstrb_i  (m_wstrb),
    .m_ready_o  (m_ready),
    .m_rvalid_o (m_rvalid),
    .m_rdata_o  (m_rdata),
    .s_avalid_o (s_avalid),
    .s_addr_o   (s_addr),
    .s_wdata_o  (s_wdata),
    .s_wstrb_o  (s_wstrb),
    .s_ready_i  (s_ready),
    .s_rvalid_i (s_rvalid),
    .s_rdata_i  (s_rdata),
    .owner_o    (owner),
    .busy_o     (busy)
  );

  // One record per clock cycle: inputs applied, then outputs expected before the edge.
  typedef struct {
    int          tag;
    logic [1:0]  avalid;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        sready;
    logic        srvalid;
    logic [31:0] srdata;
    logic [1:0]  e_ready;
    logic [1:0]  e_rvalid;
    logic        e_savalid;
    logic [15:0] e_saddr;
    logic [31:0] e_swdata;
    logic [3:0]  e_swstrb;
    logic        e_owner;
    logic        e_busy;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t        vecs[$];
  int          errors = 0;
  int          checks = 0;
  int          acc0 = 0;
  int          acc1 = 0;
  int          cur_tag;
  logic [31:0] cur_addr;
  logic [63:0] cur_wdata;
  logic [7:0]  cur_wstrb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(
    input logic [1:0] av, input logic sr, input logic srv, input logic [31:0] srd,
    input logic [1:0] er, input logic [1:0] erv, input logic esa, input logic [15:0] esaddr,
    input logic [31:0] eswd, input logic [3:0] esws, input logic eo, input logic eb,
    input logic [31:0] erd);
    vec_t v;
    v.tag = cur_tag;       v.avalid = av;          v.addr = cur_addr;
    v.wdata = cur_wdata;   v.wstrb = cur_wstrb;    v.sready = sr;
    v.srvalid = srv;       v.srdata = srd;         v.e_ready = er;
    v.e_rvalid = erv;      v.e_savalid = esa;      v.e_saddr = esaddr;
    v.e_swdata = eswd;     v.e_swstrb = esws;      v.e_owner = eo;
    v.e_busy = eb;         v.e_rdata = erd;
    vecs.push_back(v);
  endfunction

  initial begin
    // Single write from master 0; pointer moves to 1 afterwards.
    cur_tag = 1; cur_addr = {16'h0, 16'h0004}; cur_wdata = {32'h0, 32'hA5}; cur_wstrb = {4'h0, 4'h1};
    add(2'b01, 1, 0, 0, 2'b00, 2'b00, 0, 16'h0, 32'h0, 4'h0, 0, 0, 0);
    add(2'b01, 1, 0, 0, 2'b01, 2'b00, 1, 16'h0004, 32'hA5, 4'h1, 0, 1, 0);
    add(2'b00, 1, 0, 0, 2'b00, 2'b00, 0, 16'h0, 32'h0, 4'h0, 0, 0, 0);

    // Read from master 1, response two cycles after acceptance.
    cur_tag = 2; cur_addr = {16'h0010, 16'h0}; cur_wdata = 64'h0; cur_wstrb = 8'h00;
    add(2'b10, 1, 0, 0, 2'b00, 2'b00, 0, 16'h0, 32'h0, 4'h0, 0, 0, 0);
    add(2'b10, 1, 0, 0, 2'b10, 2'b00, 1, 16'h0010, 32'h0, 4'h0, 1, 1, 0);
    add(2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 16'h0, 32'h0, 4'h0, 1, 1, 0);
    add(2'b00, 0, 1, 32'hDEADBEEF, 2'b00, 2'b10, 0, 16'h0, 32'h0, 4'h0, 1, 1, 32'hDEADBEEF);
    add(2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 16'h0, 32'h0, 4'h0, 1, 0, 0);

    // Both masters write continuously: grants alternate 0,1,0,1,...
    cur_tag = 3; cur_addr = {16'h0200, 16'h0100}; cur_wdata = {32'h22, 32'h11}; cur_wstrb = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      logic o;
      logic prev;
      o    = (k % 2) != 0;
      prev = (k == 0) ? 1'b1 : (((k - 1) % 2) != 0);
      add(2'b11, 1, 0, 0, 2'b00, 2'b00, 0, 16'h0, 32'h0, 4'h0, prev, 0, 0);
      add(2'b11, 1, 0, 0, o ? 2'b10 : 2'b01, 2'b00, 1, o ? 16'h0200 : 16'h0100,
          o ? 32'h22 : 32'h11, 4'hF, o, 1, 0);
    end

    // Master 0 read outstanding while master 1 waits to write.
    cur_tag = 4; cur_addr = {16'h0040, 16'h0030}; cur_wdata = {32'h44, 32'h0}; cur_wstrb = {4'h3, 4'h0};
    add(2'b11, 1, 0, 0, 2'b00, 2'b00, 0, 16'h0, 32'h0, 4'h0, 1, 0, 0);
    add(2'b11, 1, 0, 0, 2'b01, 2'b00, 1, 16'h0030, 32'h0, 4'h0, 0, 1, 0);
    add(2'b10, 1, 0, 0, 2'b00, 2'b00, 0, 16'h0, 32'h0, 4'h0, 0, 1, 0);
    add(2'b10, 1, 0, 0, 2'b00, 2'b00, 0, 16'h0, 32'h0, 4'h0, 0, 1, 0);
    add(2'b10, 1, 1, 32'h12345678, 2'b00, 2'b01, 0, 16'h0, 32'h0, 4'h0, 0, 1, 32'h12345678);
    add(2'b10, 1, 0, 0, 2'b00, 2'b00, 0, 16'h0, 32'h0, 4'h0, 0, 0, 0);
    add(2'b10, 1, 0, 0, 2'b10, 2'b00, 1, 16'h0040, 32'h44, 4'h3, 1, 1, 0);
    add(2'b00, 1, 1, 32'hBAD0BAD0, 2'b00, 2'b00, 0, 16'h0, 32'h0, 4'h0, 1, 0, 0);

    // Owner withdraws before ready: pointer must stay at 0.
    cur_tag = 5; cur_addr = {16'h0, 16'h0055}; cur_wdata = {32'h0, 32'h55}; cur_wstrb = {4'h0, 4'h1};
    add(2'b01, 0, 0, 0, 2'b00, 2'b00, 0, 16'h0, 32'h0, 4'h0, 1, 0, 0);
    add(2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 16'h0055, 32'h55, 4'h1, 0, 1, 0);
    add(2'b11, 1, 0, 0, 2'b00, 2'b00, 0, 16'h0, 32'h0, 4'h0, 0, 0, 0);
    add(2'b11, 1, 0, 0, 2'b01, 2'b00, 1, 16'h0055, 32'h55, 4'h1, 0, 1, 0);
    add(2'b00, 1, 0, 0, 2'b00, 2'b00, 0, 16'h0, 32'h0, 4'h0, 0, 0, 0);

    // Reset with traffic present: everything must read as idle.
    cke = 1'b1; arst = 1'b1;
    m_avalid = 2'b11; m_addr = '1; m_wdata = '1; m_wstrb = '0;
    s_ready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h55AA55AA;
    @(posedge clk); #1;
    $display("reset: busy=%b owner=%0d m_ready=%b m_rvalid=%b s_avalid=%b", busy, owner, m_ready, m_rvalid, s_avalid);
    chk("reset busy", busy, 0);
    chk("reset owner", owner, 0);
    chk("reset m_ready", m_ready, 0);
    chk("reset m_rvalid", m_rvalid, 0);
    chk("reset s_avalid", s_avalid, 0);
    s_rvalid = 1'b0;
    arst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      m_avalid = vecs[i].avalid; m_addr = vecs[i].addr; m_wdata = vecs[i].wdata;
      m_wstrb = vecs[i].wstrb;   s_ready = vecs[i].sready; s_rvalid = vecs[i].srvalid;
      s_rdata = vecs[i].srdata;
      #1;
      $display("vec %0d (test %0d): avalid=%b ready=%b rvalid=%b s_avalid=%b s_addr=%h owner=%0d busy=%b",
               i, vecs[i].tag, m_avalid, m_ready, m_rvalid, s_avalid, s_addr, owner, busy);
      chk($sformatf("v%0d m_ready", i), m_ready, vecs[i].e_ready);
      chk($sformatf("v%0d m_rvalid", i), m_rvalid, vecs[i].e_rvalid);
      chk($sformatf("v%0d s_avalid", i), s_avalid, vecs[i].e_savalid);
      chk($sformatf("v%0d s_addr", i), s_addr, vecs[i].e_saddr);
      chk($sformatf("v%0d s_wdata", i), s_wdata, vecs[i].e_swdata);
      chk($sformatf("v%0d s_wstrb", i), s_wstrb, vecs[i].e_swstrb);
      chk($sformatf("v%0d owner", i), owner, vecs[i].e_owner);
      chk($sformatf("v%0d busy", i), busy, vecs[i].e_busy);
      if (vecs[i].e_rvalid != 2'b00) chk($sformatf("v%0d m_rdata", i), m_rdata, vecs[i].e_rdata);
      if (vecs[i].tag == 3) begin
        if (m_avalid[0] && m_ready[0]) acc0++;
        if (m_avalid[1] && m_ready[1]) acc1++;
      end
      @(posedge clk); #1;
    end
    chk("fair acc m0", acc0, 4);
    chk("fair acc m1", acc1, 4);

    // Clock enable low: a pending request must not be arbitrated.
    m_avalid = 2'b01; m_addr = {16'h0, 16'h0ABC}; m_wdata = {32'h0, 32'hCAFEF00D};
    m_wstrb = {4'h0, 4'hF}; s_ready = 1'b0; s_rvalid = 1'b0; cke = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      $display("cke low cycle %0d: busy=%b", c, busy);
      chk("cke hold busy", busy, 0);
    end
    cke = 1'b1;
    @(posedge clk); #1;

    // Slave stalls a write for five cycles; accepted on the sixth.
    for (int c = 0; c < 5; c++) begin
      $display("stall cycle %0d: s_avalid=%b s_addr=%h m_ready=%b", c, s_avalid, s_addr, m_ready);
      chk("stall s_avalid", s_avalid, 1);
      chk("stall s_addr", s_addr, 16'h0ABC);
      chk("stall s_wdata", s_wdata, 32'hCAFEF00D);
      chk("stall m_ready", m_ready, 2'b00);
      @(posedge clk); #1;
    end
    s_ready = 1'b1; #1;
    $display("stall accept: m_ready=%b", m_ready);
    chk("stall accept m_ready", m_ready, 2'b01);
    @(posedge clk); #1;
    m_avalid = 2'b00; #1;
    chk("stall done busy", busy, 0);

    // Reset during WAIT_RSP, followed by a late response.
    m_avalid = 2'b10; m_addr = {16'h0077, 16'h0}; m_wstrb = 8'h00;
    @(posedge clk); #1;
    $display("reset seq grant: owner=%0d m_ready=%b", owner, m_ready);
    chk("rst seq owner", owner, 1);
    chk("rst seq m_ready", m_ready, 2'b10);
    @(posedge clk); #1;
    m_avalid = 2'b00; #1;
    chk("rst seq waiting", busy, 1);
    #1 arst = 1'b1; #1;
    $display("reset mid-read: busy=%b owner=%0d m_rvalid=%b", busy, owner, m_rvalid);
    chk("rst mid busy", busy, 0);
    chk("rst mid owner", owner, 0);
    chk("rst mid m_ready", m_ready, 2'b00);
    chk("rst mid s_avalid", s_avalid, 0);
    #1 arst = 1'b0;
    @(posedge clk); #1;
    s_rvalid = 1'b1; s_rdata = 32'hFEEDFACE; #1;
    $display("late rvalid: m_rvalid=%b busy=%b", m_rvalid, busy);
    chk("late rvalid dropped", m_rvalid, 2'b00);
    chk("late rvalid busy", busy, 0);
    @(posedge clk); #1;
    s_rvalid = 1'b0; #1;
    chk("after late owner", owner, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
